// File: rtl/input_port_vc_buffer.sv
// Router input port: per-VC flit FIFOs, each with a small IDLE/VA/ACTIVE FSM in front of the VC and switch allocators.
// Optional protocol checking is compiled in with `define IB_ERROR_CHECK_EN; without it error_o is tied low.

package noc_params;
    localparam int PORT_NUM  = 5;
    localparam int PORT_SIZE = $clog2(PORT_NUM);
    localparam int VC_SIZE   = 1;
    localparam int PAYLOAD_W = 32;
endpackage

module input_port_vc_buffer
    import noc_params::*;
#(
    parameter int VC_NUM      = 2,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flit_valid_i,
    input  logic [VC_SIZE-1:0]            flit_vc_i,
    input  logic [1:0]                    flit_type_i,
    input  logic [PORT_SIZE-1:0]          flit_port_i,
    input  logic [PAYLOAD_W-1:0]          flit_payload_i,
    output logic [VC_NUM-1:0]             vc_request_o,
    output logic [VC_NUM*PORT_SIZE-1:0]   out_port_o,
    input  logic [VC_NUM-1:0]             vc_valid_i,
    input  logic [VC_NUM*VC_SIZE-1:0]     vc_new_i,
    output logic [VC_NUM-1:0]             sa_request_o,
    input  logic [VC_NUM-1:0]             sa_grant_i,
    output logic                          out_valid_o,
    output logic [VC_SIZE-1:0]            out_vc_o,
    output logic [PORT_SIZE-1:0]          out_port_sel_o,
    output logic [1:0]                    out_type_o,
    output logic [PAYLOAD_W-1:0]          out_payload_o,
    output logic [VC_NUM-1:0]             idle_o,
    output logic                          error_o
);

    localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);
    localparam logic [1:0] T_HEAD     = 2'd0;
    localparam logic [1:0] T_TAIL     = 2'd2;
    localparam logic [1:0] T_HEADTAIL = 2'd3;

    typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_t;

    logic [1:0]           type_mem    [VC_NUM][BUFFER_SIZE];
    logic [PORT_SIZE-1:0] port_mem    [VC_NUM][BUFFER_SIZE];
    logic [PAYLOAD_W-1:0] payload_mem [VC_NUM][BUFFER_SIZE];

    logic [PTR_W-1:0]     rd_ptr     [VC_NUM];
    logic [PTR_W-1:0]     wr_ptr     [VC_NUM];
    logic [CNT_W-1:0]     count      [VC_NUM];
    vc_state_t            state      [VC_NUM];
    logic [VC_SIZE-1:0]   vc_latched [VC_NUM];

    logic [1:0]           head_type  [VC_NUM];
    logic [PORT_SIZE-1:0] head_port  [VC_NUM];
    logic [VC_NUM-1:0]    not_empty, full, head_start, discard;
    logic [VC_NUM-1:0]    wr_req, wr_en, pop, sa_req, sa_win;

    logic [VC_SIZE-1:0]   sel_vc;
    logic [1:0]           sel_type;
    logic [PORT_SIZE-1:0] sel_port;
    logic [PAYLOAD_W-1:0] sel_payload;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            head_type[v]  = type_mem[v][rd_ptr[v]];
            head_port[v]  = port_mem[v][rd_ptr[v]];
            not_empty[v]  = (count[v] != '0);
            full[v]       = (count[v] == FULL_CNT);
            head_start[v] = (head_type[v] == T_HEAD) || (head_type[v] == T_HEADTAIL);
            // A stray BODY/TAIL at the head of an idle VC can never be routed, so it is dropped.
            discard[v]    = (state[v] == IDLE) && not_empty[v] && !head_start[v];
            sa_req[v]     = (state[v] == ACTIVE) && not_empty[v];
            wr_req[v]     = flit_valid_i && (flit_vc_i == VC_SIZE'(v));
        end
    end

    // Only one grant is honoured even if the allocator misbehaves; lowest VC wins.
    always_comb begin
        sa_win      = '0;
        sel_vc      = '0;
        sel_type    = '0;
        sel_port    = '0;
        sel_payload = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (sa_req[v] && sa_grant_i[v] && (sa_win == '0)) begin
                sa_win[v]   = 1'b1;
                sel_vc      = vc_latched[v];
                sel_type    = head_type[v];
                sel_port    = head_port[v];
                sel_payload = payload_mem[v][rd_ptr[v]];
            end
        end
    end

    // A full FIFO still accepts a write when its head leaves on the same edge.
    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            pop[v]   = sa_win[v] || discard[v];
            wr_en[v] = wr_req[v] && (!full[v] || pop[v]);
        end
    end

    always_comb begin
        vc_request_o = '0;
        out_port_o   = '0;
        idle_o       = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (state[v] == VA) begin
                vc_request_o[v]                       = 1'b1;
                out_port_o[v*PORT_SIZE +: PORT_SIZE] = head_port[v];
            end
            idle_o[v] = (state[v] == IDLE) && !not_empty[v];
        end
    end

    assign sa_request_o = sa_req;

    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (wr_en[v]) begin
                type_mem[v][wr_ptr[v]]    <= flit_type_i;
                port_mem[v][wr_ptr[v]]    <= flit_port_i;
                payload_mem[v][wr_ptr[v]] <= flit_payload_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                rd_ptr[v]     <= '0;
                wr_ptr[v]     <= '0;
                count[v]      <= '0;
                state[v]      <= IDLE;
                vc_latched[v] <= '0;
            end
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (wr_en[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
                if (pop[v])   rd_ptr[v] <= ptr_inc(rd_ptr[v]);
                if (wr_en[v] && !pop[v])
                    count[v] <= count[v] + 1'b1;
                else if (pop[v] && !wr_en[v])
                    count[v] <= count[v] - 1'b1;

                case (state[v])
                    IDLE: begin
                        if (not_empty[v] && head_start[v]) state[v] <= VA;
                    end
                    VA: begin
                        if (vc_valid_i[v]) begin
                            vc_latched[v] <= vc_new_i[v*VC_SIZE +: VC_SIZE];
                            state[v]      <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (sa_win[v] && ((head_type[v] == T_TAIL) || (head_type[v] == T_HEADTAIL)))
                            state[v] <= IDLE;
                    end
                    default: state[v] <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o    <= 1'b0;
            out_vc_o       <= '0;
            out_port_sel_o <= '0;
            out_type_o     <= '0;
            out_payload_o  <= '0;
        end else begin
            out_valid_o    <= |sa_win;
            out_vc_o       <= sel_vc;
            out_port_sel_o <= sel_port;
            out_type_o     <= sel_type;
            out_payload_o  <= sel_payload;
        end
    end

`ifdef IB_ERROR_CHECK_EN
    logic [VC_NUM-1:0] tail_open;
    logic              err_event;
    logic              error_q;

    // tail_open marks a VC whose most recently written packet has not yet seen its TAIL.
    always_comb begin
        err_event = ((sa_grant_i & (sa_grant_i - VC_NUM'(1))) != '0);
        for (int v = 0; v < VC_NUM; v++) begin
            if (wr_req[v] && full[v] && !pop[v]) err_event = 1'b1;
            if (discard[v]) err_event = 1'b1;
            if (wr_req[v] && ((flit_type_i == T_HEAD) || (flit_type_i == T_HEADTAIL))
                && (state[v] != IDLE) && tail_open[v])
                err_event = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tail_open <= '0;
            error_q   <= 1'b0;
        end else begin
            error_q <= error_q | err_event;
            for (int v = 0; v < VC_NUM; v++) begin
                if (wr_en[v]) begin
                    if (flit_type_i == T_HEAD)
                        tail_open[v] <= 1'b1;
                    else if ((flit_type_i == T_TAIL) || (flit_type_i == T_HEADTAIL))
                        tail_open[v] <= 1'b0;
                end
            end
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_input_port_vc_buffer.sv
// Directed bench for input_port_vc_buffer: a per-cycle vector table followed by
// hand-written sequences for fill/overflow, full-FIFO streaming, interleaving, reset and discard.

module tb_input_port_vc_buffer;
    import noc_params::*;

`ifdef IB_ERROR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flit_valid_i;
    logic [VC_SIZE-1:0]   flit_vc_i;
    logic [1:0]           flit_type_i;
    logic [PORT_SIZE-1:0] flit_port_i;
    logic [PAYLOAD_W-1:0] flit_payload_i;
    logic [1:0]           vc_request_o;
    logic [2*PORT_SIZE-1:0] out_port_o;
    logic [1:0]           vc_valid_i;
    logic [2*VC_SIZE-1:0] vc_new_i;
    logic [1:0]           sa_request_o;
    logic [1:0]           sa_grant_i;
    logic                 out_valid_o;
    logic [VC_SIZE-1:0]   out_vc_o;
    logic [PORT_SIZE-1:0] out_port_sel_o;
    logic [1:0]           out_type_o;
    logic [PAYLOAD_W-1:0] out_payload_o;
    logic [1:0]           idle_o;
    logic                 error_o;

    int n_cmp  = 0;
    int n_fail = 0;

    input_port_vc_buffer #(.VC_NUM(2), .BUFFER_SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .flit_valid_i(flit_valid_i), .flit_vc_i(flit_vc_i), .flit_type_i(flit_type_i),
        .flit_port_i(flit_port_i), .flit_payload_i(flit_payload_i),
        .vc_request_o(vc_request_o), .out_port_o(out_port_o),
        .vc_valid_i(vc_valid_i), .vc_new_i(vc_new_i),
        .sa_request_o(sa_request_o), .sa_grant_i(sa_grant_i),
        .out_valid_o(out_valid_o), .out_vc_o(out_vc_o), .out_port_sel_o(out_port_sel_o),
        .out_type_o(out_type_o), .out_payload_o(out_payload_o),
        .idle_o(idle_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fv;
        logic [0:0]  vc;
        logic [1:0]  ftype;
        logic [2:0]  port;
        logic [31:0] payload;
        logic [1:0]  vv;
        logic [1:0]  vnew;
        logic [1:0]  grant;
        logic [1:0]  e_vcreq;
        logic [5:0]  e_outport;
        logic [1:0]  e_sareq;
        logic        e_ov;
        logic [0:0]  e_ovc;
        logic [2:0]  e_oport;
        logic [1:0]  e_otype;
        logic [31:0] e_opay;
        logic [1:0]  e_idle;
    } vec_t;

    vec_t vecs [13];
    vec_t h;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge, then sample #1 after the following edge.
    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        flit_valid_i   = v.fv;
        flit_vc_i      = v.vc;
        flit_type_i    = v.ftype;
        flit_port_i    = v.port;
        flit_payload_i = v.payload;
        vc_valid_i     = v.vv;
        vc_new_i       = v.vnew;
        sa_grant_i     = v.grant;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int row);
        check($sformatf("row%0d vc_request", row), 32'(vc_request_o), 32'(v.e_vcreq));
        check($sformatf("row%0d out_port", row), 32'(out_port_o), 32'(v.e_outport));
        check($sformatf("row%0d sa_request", row), 32'(sa_request_o), 32'(v.e_sareq));
        check($sformatf("row%0d out_valid", row), 32'(out_valid_o), 32'(v.e_ov));
        check($sformatf("row%0d idle", row), 32'(idle_o), 32'(v.e_idle));
        check($sformatf("row%0d error", row), 32'(error_o), 32'(1'b0));
        if (v.e_ov) begin
            check($sformatf("row%0d out_vc", row), 32'(out_vc_o), 32'(v.e_ovc));
            check($sformatf("row%0d out_port_sel", row), 32'(out_port_sel_o), 32'(v.e_oport));
            check($sformatf("row%0d out_type", row), 32'(out_type_o), 32'(v.e_otype));
            check($sformatf("row%0d out_payload", row), out_payload_o, v.e_opay);
        end
    endtask

    function automatic vec_t idle_vec();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    initial begin
        // rst fv vc type port payload vv vnew grant | vcreq outport sareq ov ovc oport otype opay idle
        vecs[0]  = '{0,1,0,3,3,32'hA0A00001, 2'b00,2'b00,2'b00, 2'b00,6'o00,2'b00, 0,0,0,0,32'h0,        2'b10};
        vecs[1]  = '{0,0,0,0,0,32'h0,        2'b00,2'b00,2'b00, 2'b01,6'o03,2'b00, 0,0,0,0,32'h0,        2'b10};
        vecs[2]  = '{0,0,0,0,0,32'h0,        2'b01,2'b01,2'b00, 2'b00,6'o00,2'b01, 0,0,0,0,32'h0,        2'b10};
        vecs[3]  = '{0,0,0,0,0,32'h0,        2'b00,2'b00,2'b01, 2'b00,6'o00,2'b00, 1,1,3,3,32'hA0A00001, 2'b11};
        vecs[4]  = '{0,0,0,0,0,32'h0,        2'b00,2'b00,2'b00, 2'b00,6'o00,2'b00, 0,0,0,0,32'h0,        2'b11};
        vecs[5]  = '{0,1,1,0,2,32'hB0000000, 2'b10,2'b10,2'b00, 2'b00,6'o00,2'b00, 0,0,0,0,32'h0,        2'b01};
        vecs[6]  = '{0,1,1,1,2,32'hB0000001, 2'b00,2'b00,2'b00, 2'b10,6'o20,2'b00, 0,0,0,0,32'h0,        2'b01};
        vecs[7]  = '{0,1,1,1,2,32'hB0000002, 2'b10,2'b10,2'b00, 2'b00,6'o00,2'b10, 0,0,0,0,32'h0,        2'b01};
        vecs[8]  = '{0,1,1,2,2,32'hB0000003, 2'b00,2'b00,2'b10, 2'b00,6'o00,2'b10, 1,1,2,0,32'hB0000000, 2'b01};
        vecs[9]  = '{0,0,0,0,0,32'h0,        2'b00,2'b00,2'b10, 2'b00,6'o00,2'b10, 1,1,2,1,32'hB0000001, 2'b01};
        vecs[10] = '{0,0,0,0,0,32'h0,        2'b00,2'b00,2'b10, 2'b00,6'o00,2'b10, 1,1,2,1,32'hB0000002, 2'b01};
        vecs[11] = '{0,0,0,0,0,32'h0,        2'b00,2'b00,2'b10, 2'b00,6'o00,2'b00, 1,1,2,2,32'hB0000003, 2'b11};
        vecs[12] = '{0,0,0,0,0,32'h0,        2'b00,2'b00,2'b10, 2'b00,6'o00,2'b00, 0,0,0,0,32'h0,        2'b11};

        h = idle_vec();
        h.rst = 1'b1;
        applyStimulus(h);
        applyStimulus(h);
        check("reset vc_request", 32'(vc_request_o), 32'h0);
        check("reset sa_request", 32'(sa_request_o), 32'h0);
        check("reset out_valid", 32'(out_valid_o), 32'h0);
        check("reset idle", 32'(idle_o), 32'h3);
        check("reset error", 32'(error_o), 32'h0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Fill VC0 with 8 flits while it waits in VA, then a 9th that must be dropped.
        for (int i = 0; i < 8; i++) begin
            h = idle_vec();
            h.fv = 1'b1; h.vc = 1'b0; h.ftype = (i == 0) ? 2'd0 : 2'd1; h.port = 3'd5; h.payload = 32'(i);
            applyStimulus(h);
        end
        h = idle_vec();
        h.fv = 1'b1; h.vc = 1'b0; h.ftype = 2'd1; h.port = 3'd5; h.payload = 32'hDEAD;
        applyStimulus(h);
        check("fill vc_request", 32'(vc_request_o), 32'h1);
        check("fill out_port", 32'(out_port_o), 32'o05);
        check("fill idle", 32'(idle_o), 32'h2);
        check("overflow error", 32'(error_o), 32'(EXP_ERR));

        h = idle_vec();
        h.vv = 2'b01; h.vnew = 2'b01;
        applyStimulus(h);
        check("full sa_request", 32'(sa_request_o), 32'h1);

        // Stream through the full FIFO: write and pop every cycle, then drain.
        for (int i = 0; i < 20; i++) begin
            h = idle_vec();
            h.grant = 2'b01;
            if (i < 12) begin
                h.fv = 1'b1; h.vc = 1'b0; h.ftype = (i == 11) ? 2'd2 : 2'd1;
                h.port = 3'd5; h.payload = 32'(8 + i);
            end
            applyStimulus(h);
            check($sformatf("stream%0d out_valid", i), 32'(out_valid_o), 32'h1);
            check($sformatf("stream%0d out_payload", i), out_payload_o, 32'(i));
            if (i == 0)  check("stream first type", 32'(out_type_o), 32'h0);
            if (i == 19) check("stream last type", 32'(out_type_o), 32'h2);
        end
        check("stream out_vc", 32'(out_vc_o), 32'h1);
        check("stream out_port_sel", 32'(out_port_sel_o), 32'h5);
        h = idle_vec();
        applyStimulus(h);
        check("drained out_valid", 32'(out_valid_o), 32'h0);
        check("drained sa_request", 32'(sa_request_o), 32'h0);
        check("drained idle", 32'(idle_o), 32'h3);

        // Two VCs active at once, grants alternating.
        h = idle_vec(); h.fv = 1; h.vc = 0; h.ftype = 0; h.port = 1; h.payload = 32'h100; applyStimulus(h);
        h = idle_vec(); h.fv = 1; h.vc = 1; h.ftype = 0; h.port = 4; h.payload = 32'h200; applyStimulus(h);
        h = idle_vec(); h.fv = 1; h.vc = 0; h.ftype = 1; h.port = 1; h.payload = 32'h101;
        h.vv = 2'b01; h.vnew = 2'b01; applyStimulus(h);
        h = idle_vec(); h.fv = 1; h.vc = 1; h.ftype = 1; h.port = 4; h.payload = 32'h201;
        h.vv = 2'b10; h.vnew = 2'b00; applyStimulus(h);
        check("ilv both active", 32'(sa_request_o), 32'h3);
        for (int i = 0; i < 4; i++) begin
            h = idle_vec();
            h.grant = (i % 2 == 0) ? 2'b01 : 2'b10;
            if (i == 0) begin
                h.fv = 1; h.vc = 0; h.ftype = 1; h.port = 1; h.payload = 32'h102;
            end
            applyStimulus(h);
            check($sformatf("ilv%0d out_valid", i), 32'(out_valid_o), 32'h1);
            check($sformatf("ilv%0d out_vc", i), 32'(out_vc_o), (i % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("ilv%0d out_port_sel", i), 32'(out_port_sel_o), (i % 2 == 0) ? 32'h1 : 32'h4);
            check($sformatf("ilv%0d out_payload", i), out_payload_o,
                  ((i % 2 == 0) ? 32'h100 : 32'h200) + 32'(i / 2));
        end
        check("ilv pending", 32'(sa_request_o), 32'h1);

        h = idle_vec(); h.rst = 1'b1; h.grant = 2'b01; applyStimulus(h);
        check("midrst vc_request", 32'(vc_request_o), 32'h0);
        check("midrst sa_request", 32'(sa_request_o), 32'h0);
        check("midrst out_valid", 32'(out_valid_o), 32'h0);
        check("midrst out_vc", 32'(out_vc_o), 32'h0);
        check("midrst out_port_sel", 32'(out_port_sel_o), 32'h0);
        check("midrst out_type", 32'(out_type_o), 32'h0);
        check("midrst out_payload", out_payload_o, 32'h0);
        check("midrst idle", 32'(idle_o), 32'h3);
        check("midrst error", 32'(error_o), 32'h0);
        h = idle_vec(); h.grant = 2'b01; applyStimulus(h);
        check("postrst sa_request", 32'(sa_request_o), 32'h0);
        check("postrst out_valid", 32'(out_valid_o), 32'h0);
        check("postrst idle", 32'(idle_o), 32'h3);

        // A BODY flit landing in an idle VC is popped without ever requesting.
        h = idle_vec(); h.fv = 1; h.vc = 1; h.ftype = 1; h.port = 2; h.payload = 32'h55; applyStimulus(h);
        check("stray stored idle", 32'(idle_o), 32'h1);
        h = idle_vec(); applyStimulus(h);
        check("stray discarded idle", 32'(idle_o), 32'h3);
        check("stray vc_request", 32'(vc_request_o), 32'h0);
        check("stray out_valid", 32'(out_valid_o), 32'h0);
        check("stray error", 32'(error_o), 32'(EXP_ERR));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
